// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, parity-mode constants and parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest word any UART in this family carries; narrower words are zero-extended.
    localparam int c_MAX_DATA_BITS = 9;

    // Returns the parity bit a transmitter would send for this word and mode.
    function automatic logic parity_calc(
        input logic [c_MAX_DATA_BITS-1:0] word,
        input int                         mode
    );
        logic w_xor;
        w_xor = ^word;
        if (mode == PARITY_EVEN) begin
            return w_xor;
        end else if (mode == PARITY_ODD) begin
            return ~w_xor;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchroniser for an idle-high serial line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx_async,
    output logic o_rx_sync
);

    logic r_meta_q;
    logic r_sync_q;
    logic w_meta_d;
    logic w_sync_d;

    always_comb begin
        w_meta_d = i_rx_async;
        w_sync_d = r_meta_q;
    end

    // Reset to the idle level so no false start is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
        end
    end

    assign o_rx_sync = r_sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with parity, 1/2 stop bits and error flags.
//            Define UART_RX_SYNC_EN to insert a 2-flop synchroniser on Rx.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rx,
    input  logic                 Tick,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxAccept,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk        (Clock),
        .rst        (Reset),
        .i_rx_async (Rx),
        .o_rx_sync  (w_rx)
    );
`else
    assign w_rx = Rx;
`endif

    rx_state_t             r_state_q,     w_state_d;
    logic [c_TICK_W-1:0]   r_tick_cnt_q,  w_tick_cnt_d;
    logic [c_BIT_W-1:0]    r_bit_cnt_q,   w_bit_cnt_d;
    logic [DATA_BITS-1:0]  r_shift_q,     w_shift_d;
    logic                  r_frame_err_q, w_frame_err_d;
    logic                  r_par_err_q,   w_par_err_d;
    logic                  w_done;

    logic [DATA_BITS-1:0]  r_rx_data_q,   w_rx_data_d;
    logic                  r_rx_valid_q,  w_rx_valid_d;
    logic                  r_ferr_out_q,  w_ferr_out_d;
    logic                  r_perr_out_q,  w_perr_out_d;
    logic                  r_overrun_q,   w_overrun_d;

    // Frame sequencing: every advance is gated by Tick.
    always_comb begin
        w_state_d     = r_state_q;
        w_tick_cnt_d  = r_tick_cnt_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_shift_d     = r_shift_q;
        w_frame_err_d = r_frame_err_q;
        w_par_err_d   = r_par_err_q;
        w_done        = 1'b0;

        if (Tick) begin
            case (r_state_q)
                IDLE: begin
                    if (!w_rx) begin
                        w_state_d     = START;
                        w_tick_cnt_d  = '0;
                        w_frame_err_d = 1'b0;
                        w_par_err_d   = 1'b0;
                    end
                end
                START: begin
                    if (r_tick_cnt_q == c_TICK_MID) begin
                        w_tick_cnt_d = '0;
                        w_bit_cnt_d  = '0;
                        w_state_d    = w_rx ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + c_TICK_W'(1);
                    end
                end
                DATA: begin
                    if (r_tick_cnt_q == c_TICK_LAST) begin
                        w_shift_d    = {w_rx, r_shift_q[DATA_BITS-1:1]};
                        w_tick_cnt_d = '0;
                        w_bit_cnt_d  = r_bit_cnt_q + c_BIT_W'(1);
                        if (r_bit_cnt_q == c_DATA_LAST) begin
                            w_bit_cnt_d = '0;
                            w_state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + c_TICK_W'(1);
                    end
                end
                PARITY: begin
                    if (r_tick_cnt_q == c_TICK_LAST) begin
                        w_par_err_d  = w_rx ^ parity_calc(c_MAX_DATA_BITS'(r_shift_q), PARITY_MODE);
                        w_tick_cnt_d = '0;
                        w_state_d    = STOP;
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + c_TICK_W'(1);
                    end
                end
                STOP: begin
                    if (r_tick_cnt_q == c_TICK_LAST) begin
                        w_tick_cnt_d = '0;
                        w_bit_cnt_d  = r_bit_cnt_q + c_BIT_W'(1);
                        if (!w_rx) begin
                            w_frame_err_d = 1'b1;
                        end
                        // Returning to IDLE right here lets the next start edge be seen half a bit early.
                        if (r_bit_cnt_q == c_STOP_LAST) begin
                            w_bit_cnt_d = '0;
                            w_state_d   = IDLE;
                            w_done      = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt_q + c_TICK_W'(1);
                    end
                end
                default: begin
                    w_state_d    = IDLE;
                    w_tick_cnt_d = '0;
                    w_bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // Output handshake runs every clock; a completion overrides a same-cycle accept.
    always_comb begin
        w_rx_data_d  = r_rx_data_q;
        w_rx_valid_d = r_rx_valid_q;
        w_ferr_out_d = r_ferr_out_q;
        w_perr_out_d = r_perr_out_q;
        w_overrun_d  = r_overrun_q;

        if (r_rx_valid_q && RxAccept) begin
            w_rx_valid_d = 1'b0;
        end

        if (w_done) begin
            w_rx_data_d  = r_shift_q;
            w_rx_valid_d = 1'b1;
            w_ferr_out_d = w_frame_err_d;
            w_perr_out_d = w_par_err_d;
            w_overrun_d  = r_rx_valid_q && !RxAccept;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q     <= IDLE;
            r_tick_cnt_q  <= '0;
            r_bit_cnt_q   <= '0;
            r_shift_q     <= '0;
            r_frame_err_q <= 1'b0;
            r_par_err_q   <= 1'b0;
            r_rx_data_q   <= '0;
            r_rx_valid_q  <= 1'b0;
            r_ferr_out_q  <= 1'b0;
            r_perr_out_q  <= 1'b0;
            r_overrun_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_tick_cnt_q  <= w_tick_cnt_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_shift_q     <= w_shift_d;
            r_frame_err_q <= w_frame_err_d;
            r_par_err_q   <= w_par_err_d;
            r_rx_data_q   <= w_rx_data_d;
            r_rx_valid_q  <= w_rx_valid_d;
            r_ferr_out_q  <= w_ferr_out_d;
            r_perr_out_q  <= w_perr_out_d;
            r_overrun_q   <= w_overrun_d;
        end
    end

    assign RxData    = r_rx_data_q;
    assign RxValid   = r_rx_valid_q;
    assign FrameErr  = r_ferr_out_q;
    assign ParityErr = r_perr_out_q;
    assign Overrun   = r_overrun_q;
    assign Busy      = (r_state_q != IDLE);

endmodule : uart_rx_param
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param over four parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_OS = 16;
    localparam int c_N  = 4;

    // Instance configs: 0 = 8N1, 1 = 8E1, 2 = 8N2, 3 = 8O2
    int par_mode [c_N] = '{0, 1, 0, 2};
    int stop_n   [c_N] = '{1, 1, 2, 2};

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    int         tick_div = 0;
    logic       rx    [c_N];
    logic       acc   [c_N];
    logic [7:0] rdata [c_N];
    logic       valid [c_N];
    logic       ferr  [c_N];
    logic       perr  [c_N];
    logic       ovr   [c_N];
    logic       busy  [c_N];

    int   checks   = 0;
    int   failures = 0;
    logic pre_valid;
    logic post_valid;
    logic mvalid [c_N];

    for (genvar i = 0; i < c_N; i++) begin : g_dut
        uart_rx_param #(
            .DATA_BITS   (8),
            .OVERSAMPLE  (c_OS),
            .PARITY_MODE ((i == 1) ? 1 : ((i == 3) ? 2 : 0)),
            .STOP_BITS   ((i >= 2) ? 2 : 1)
        ) u_dut (
            .Clock     (clk),
            .Reset     (rst),
            .Rx        (rx[i]),
            .Tick      (tick),
            .RxData    (rdata[i]),
            .RxValid   (valid[i]),
            .RxAccept  (acc[i]),
            .FrameErr  (ferr[i]),
            .ParityErr (perr[i]),
            .Overrun   (ovr[i]),
            .Busy      (busy[i])
        );
    end

    always #5 clk = ~clk;

    // One-clock Tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        tick     = (tick_div == 0);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge after a clock edge that carried Tick.
    task automatic wait_tick();
        @(posedge clk);
        while (!tick) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input int idx, input logic v);
        rx[idx] = v;
        repeat (c_OS) wait_tick();
    endtask

    task automatic idle_bits(input int idx, input int n);
        rx[idx] = 1'b1;
        repeat (n * c_OS) wait_tick();
    endtask

    // Drives one whole frame; the last stop bit is sampled on its 9th Tick, where
    // RxValid is captured just before and just after that edge.
    task automatic send_frame(input int idx, input logic [7:0] d, input logic pb,
                              input logic [1:0] sv, input bit acc_on_done);
        send_bit(idx, 1'b0);
        for (int b = 0; b < 8; b++) send_bit(idx, d[b]);
        if (par_mode[idx] != 0) send_bit(idx, pb);
        if (stop_n[idx] == 2) send_bit(idx, sv[0]);
        rx[idx] = (stop_n[idx] == 2) ? sv[1] : sv[0];
        repeat (c_OS / 2) wait_tick();
        repeat (3) @(negedge clk);
        pre_valid = valid[idx];
        if (acc_on_done) acc[idx] = 1'b1;
        @(negedge clk);
        acc[idx]   = 1'b0;
        post_valid = valid[idx];
        repeat (c_OS / 2 - 1) wait_tick();
        rx[idx] = 1'b1;
    endtask

    task automatic accept_word(input int idx);
        @(negedge clk);
        acc[idx] = 1'b1;
        @(negedge clk);
        acc[idx] = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [7:0] ed,
                               input logic ep, input logic ef, input logic eo);
        check({tag, "_valid"}, 32'(valid[idx]), 32'd1);
        check({tag, "_data"},  32'(rdata[idx]), 32'(ed));
        check({tag, "_perr"},  32'(perr[idx]),  32'(ep));
        check({tag, "_ferr"},  32'(ferr[idx]),  32'(ef));
        check({tag, "_ovr"},   32'(ovr[idx]),   32'(eo));
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       pb;
        logic [1:0] sv;
        logic [7:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        for (int i = 0; i < c_N; i++) begin
            rx[i]     = 1'b1;
            acc[i]    = 1'b0;
            mvalid[i] = 1'b0;
        end

        vecs[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{2, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
        vecs[4] = '{3, 8'h07, 1'b0, 2'b11, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{3, 8'h07, 1'b1, 2'b11, 8'h07, 1'b1, 1'b0};
        vecs[6] = '{2, 8'hC3, 1'b0, 2'b10, 8'hC3, 1'b0, 1'b1};
        vecs[7] = '{0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_data",  32'(rdata[0]), 32'd0);
        check("rst_ferr",  32'(ferr[0]),  32'd0);
        check("rst_perr",  32'(perr[0]),  32'd0);
        check("rst_ovr",   32'(ovr[0]),   32'd0);
        idle_bits(0, 1);

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            send_frame(vecs[v].idx, vecs[v].data, vecs[v].pb, vecs[v].sv, 1'b0);
            check({tag, "_pre_valid"},  32'(pre_valid),  32'd0);
            check({tag, "_post_valid"}, 32'(post_valid), 32'd1);
            check_frame(tag, vecs[v].idx, vecs[v].e_data, vecs[v].e_perr, vecs[v].e_ferr, 1'b0);
            repeat (5) wait_tick();
            check({tag, "_hold_valid"}, 32'(valid[vecs[v].idx]), 32'd1);
            accept_word(vecs[v].idx);
            check({tag, "_acc_valid"}, 32'(valid[vecs[v].idx]), 32'd0);
            check({tag, "_acc_data"},  32'(rdata[vecs[v].idx]), 32'(vecs[v].e_data));
            idle_bits(vecs[v].idx, 2);
        end

        // False start: line low for 4 Ticks only
        rx[0] = 1'b0;
        wait_tick();
        check("fs_busy_detect", 32'(busy[0]), 32'd1);
        repeat (3) wait_tick();
        rx[0] = 1'b1;
        repeat (4) wait_tick();
        check("fs_busy_t8", 32'(busy[0]), 32'd1);
        wait_tick();
        check("fs_busy_t9", 32'(busy[0]), 32'd0);
        repeat (c_OS) wait_tick();
        check("fs_valid", 32'(valid[0]), 32'd0);

        // Back-to-back frames with no accept: overrun
        send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
        check_frame("ovr_a", 0, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0);
        check_frame("ovr_b", 0, 8'h22, 1'b0, 1'b0, 1'b1);
        accept_word(0);
        check("ovr_acc_valid", 32'(valid[0]), 32'd0);
        idle_bits(0, 1);

        // Same pair, accept coincides with the second completion
        send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
        check_frame("coacc_a", 0, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 2'b11, 1'b1);
        check_frame("coacc_b", 0, 8'h22, 1'b0, 1'b0, 1'b0);
        accept_word(0);
        idle_bits(0, 1);

        // Reset pulse during data bit 3, then a clean frame
        send_bit(0, 1'b0);
        for (int b = 0; b < 3; b++) send_bit(0, 1'(8'h96 >> b));
        rx[0] = 1'b0;
        repeat (5) wait_tick();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx[0] = 1'b1;
        check("mrst_data",  32'(rdata[0]), 32'd0);
        check("mrst_valid", 32'(valid[0]), 32'd0);
        check("mrst_busy",  32'(busy[0]),  32'd0);
        check("mrst_flags", {29'd0, ferr[0], perr[0], ovr[0]}, 32'd0);
        idle_bits(0, 3);
        check("mrst_idle_valid", 32'(valid[0]), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0);
        check_frame("mrst_clean", 0, 8'h3C, 1'b0, 1'b0, 1'b0);
        accept_word(0);
        idle_bits(0, 1);

        // Randomised frames against a frame-level model
        for (int i = 0; i < c_N; i++) mvalid[i] = valid[i];
        for (int n = 0; n < 30; n++) begin
            int         idx;
            int         amode;
            logic [7:0] d;
            logic       pok;
            logic       ideal;
            logic       pb;
            logic [1:0] sv;
            logic       ep;
            logic       ef;
            logic       eo;
            string      tag;
            idx   = int'($urandom_range(0, c_N - 1));
            amode = int'($urandom_range(0, 2));
            d     = 8'($urandom);
            pok   = ($urandom_range(0, 3) != 0);
            sv[0] = ($urandom_range(0, 3) != 0);
            sv[1] = ($urandom_range(0, 3) != 0);
            ideal = ($countones(d) % 2 == 1);
            if (par_mode[idx] == 2) ideal = ~ideal;
            pb = pok ? ideal : ~ideal;
            ep = (par_mode[idx] != 0) && !pok;
            ef = !sv[0] || ((stop_n[idx] == 2) && !sv[1]);
            eo = mvalid[idx] && (amode != 1);
            tag = $sformatf("rnd%0d_i%0d", n, idx);
            send_frame(idx, d, pb, sv, amode == 1);
            check_frame(tag, idx, d, ep, ef, eo);
            mvalid[idx] = 1'b1;
            if (amode == 2) begin
                accept_word(idx);
                check({tag, "_acc_valid"}, 32'(valid[idx]), 32'd0);
                mvalid[idx] = 1'b0;
            end
            idle_bits(idx, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_param
`default_nettype wire
